// File: rtl/fv_fifo_reader.sv
// FV FIFO read-side burst controller.
// Drains burst_len entries into a valid/ready stream via a skid buffer.
package fv_pkg;

  typedef struct packed {
    logic [7:0]  src_id;
    logic [15:0] frame_no;
    logic [7:0]  flags;
  } FV_info2FV_FIFO;

endpackage

module fv_fifo_reader
  import fv_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  FV_info2FV_FIFO   fifo_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output FV_info2FV_FIFO   out_data,
  output logic             out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(BUF_DEPTH);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] issue_left_q;
  logic [CNT_W-1:0] out_left_q;
  logic             inflight_q;

  FV_info2FV_FIFO   buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;

  logic             pop;
  logic             cap;
  logic             run;
  logic             go;
  logic             drained;
  logic [SUM_W-1:0] need;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign run       = (state_q == S_RUN);
  assign busy      = run || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign cap       = inflight_q;

  // Projected occupancy one cycle out; out_ready enters only via pop.
  assign need = SUM_W'(occ_q)
              + SUM_W'(inflight_q)
              - SUM_W'(pop);

  assign fifo_rinc = run
                  && !fifo_rempty
                  && (issue_left_q != '0)
                  && (need < DEPTH_S);

  assign go      = (state_q == S_IDLE) && start;
  assign drained = !inflight_q
                && (occ_q == '0)
                && (out_left_q == '0);

  assign out_data = out_valid ? buf_q[head_q] : '0;
  assign out_last = out_valid
                 && (out_left_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (burst_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (fifo_rinc && issue_left_q == CNT_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rinc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_left_q <= '0;
      out_left_q   <= '0;
    end else if (go && burst_len != '0) begin
      issue_left_q <= burst_len;
      out_left_q   <= burst_len;
    end else begin
      if (fifo_rinc) begin
        issue_left_q <= issue_left_q - CNT_W'(1);
      end
      if (pop) begin
        out_left_q <= out_left_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (cap) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      unique case (1'b1)
        cap && !pop: occ_q <= occ_q + OCC_W'(1);
        pop && !cap: occ_q <= occ_q - OCC_W'(1);
        default:     occ_q <= occ_q;
      endcase
    end
  end

  // Payload storage needs no reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (cap) begin
      buf_q[tail_q] <= fifo_rdata;
    end
  end

endmodule

// File: tb/tb_fv_fifo_reader.sv
// Bench for fv_fifo_reader: queue-based FIFO and stream model,
// directed plan cases plus randomized bursts.
module tb_fv_fifo_reader;
  import fv_pkg::*;

  localparam int BD = 2;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CW-1:0]  burst_len;
  logic           busy;
  logic           done;
  logic           fifo_rempty = 1'b1;
  logic           fifo_rinc;
  FV_info2FV_FIFO fifo_rdata = '0;
  logic           out_valid;
  logic           out_ready;
  FV_info2FV_FIFO out_data;
  logic           out_last;

  fv_fifo_reader #(.BUF_DEPTH(BD), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .burst_len   (burst_len),
    .busy        (busy),
    .done        (done),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .fifo_rdata  (fifo_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // FIFO model: one-cycle read latency, zero data when not read.
  FV_info2FV_FIFO fq[$];
  logic           push_en;
  FV_info2FV_FIFO push_data;
  logic           rd_vld = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      fifo_rdata  <= '0;
      rd_vld      <= 1'b0;
      fifo_rempty <= 1'b1;
    end else begin
      if (fifo_rinc && fq.size() != 0) begin
        fifo_rdata <= fq.pop_front();
        rd_vld     <= 1'b1;
      end else begin
        fifo_rdata <= '0;
        rd_vld     <= 1'b0;
      end
      if (push_en) fq.push_back(push_data);
      fifo_rempty <= (fq.size() == 0);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  FV_info2FV_FIFO exp_q[$];
  logic [32:0]    beat_q[$];
  int             rmode = 0;
  int             pat = 0;
  int             occ_m = 0;
  int             done_cnt = 0;
  int             rinc_cnt = 0;
  logic           prev_stall = 1'b0;
  FV_info2FV_FIFO prev_d;
  logic           prev_l;
  int             t_s, t_r, t_v, t_d;
  logic           r_done;

  task automatic step();
    @(posedge clk);
    #1;
    push_en = 1'b0;
    start   = 1'b0;
    case (rmode)
      1:       out_ready = (pat % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
    pat++;
  endtask

  task automatic watch();
    @(negedge clk);
    if (reset) begin
      occ_m      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(prev_d));
        chk("hold_last", 64'(out_last), 64'(prev_l));
      end
      if (fifo_rinc) begin
        rinc_cnt++;
        chk("rinc_on_empty", 64'(fifo_rempty), 64'd0);
      end
      if (out_valid && out_ready)
        beat_q.push_back({out_last, out_data});
      if (done) done_cnt++;
      occ_m = occ_m + int'(rd_vld) - int'(out_valid && out_ready);
      if (rd_vld) chk("occ_max", 64'(occ_m <= BD), 64'd1);
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  endtask

  task automatic tick();
    step();
    watch();
  endtask

  task automatic push_rand();
    FV_info2FV_FIFO e;
    e = FV_info2FV_FIFO'($urandom | 32'h1);
    push_en   = 1'b1;
    push_data = e;
    exp_q.push_back(e);
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      push_rand();
      watch();
    end
  endtask

  task automatic chk_zero_out();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rinc", 64'(fifo_rinc), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
  endtask

  task automatic burst(input int len, input int feed_rem,
                       input int feed_at, input bit feed_rnd,
                       input int mid, input bit stall_chk);
    int base, d0, r0;
    int fr;
    FV_info2FV_FIFO ev;
    logic [32:0]    gv;
    base = beat_q.size();
    d0 = done_cnt;
    r0 = rinc_cnt;
    fr = feed_rem;
    t_r = -1; t_v = -1; t_d = -1;
    r_done = 1'b0;
    step();
    start = 1'b1;
    burst_len = CW'(len);
    watch();
    t_s = cyc;
    for (int i = 0; i < 600; i++) begin
      step();
      if (fr > 0 && i >= feed_at
          && (!feed_rnd || $urandom_range(0, 1) == 1)) begin
        push_rand();
        fr--;
      end
      if (i == mid) begin
        start = 1'b1;
        burst_len = CW'(3);
      end
      watch();
      if (stall_chk && i == feed_at - 1) begin
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_rinc", 64'(fifo_rinc), 64'd0);
        chk("stall_beats", 64'(beat_q.size() - base), 64'd2);
      end
      if (fifo_rinc && t_r < 0) t_r = cyc;
      if (out_valid && t_v < 0) t_v = cyc;
      if (done) begin
        t_d = cyc;
        r_done = fifo_rinc;
        break;
      end
    end
    chk("done_seen", 64'(t_d >= 0), 64'd1);
    chk("rinc_at_done", 64'(r_done), 64'd0);
    tick();
    tick();
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("rinc_total", 64'(rinc_cnt - r0), 64'(len));
    chk("beat_total", 64'(beat_q.size() - base), 64'(len));
    for (int k = 0; k < len; k++) begin
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      gv = (base + k < beat_q.size()) ? beat_q[base + k] : '0;
      chk("beat_data", 64'(gv[31:0]), 64'(ev));
      chk("beat_last", 64'(gv[32]), 64'(k == len - 1));
    end
  endtask

  initial begin
    int base, d0, len, k;
    reset = 1'b1;
    start = 1'b0;
    burst_len = '0;
    out_ready = 1'b0;
    push_en = 1'b0;
    push_data = '0;
    repeat (3) tick();
    step();
    reset = 1'b0;
    watch();
    chk_zero_out();

    // basic burst with latency
    rmode = 0;
    preload(4);
    burst(4, 0, 0, 1'b0, -1, 1'b0);
    chk("lat_rinc", 64'(t_r - t_s), 64'd1);
    chk("lat_valid", 64'(t_v - t_s), 64'd3);
    chk("lat_done", 64'(t_d - t_s), 64'd8);
    chk("fifo_drained", 64'(fifo_rempty), 64'd1);

    // back-pressure 1,0,0 pattern
    rmode = 1;
    pat = 0;
    preload(6);
    burst(6, 0, 0, 1'b0, -1, 1'b0);

    // underflow stall then resume
    rmode = 0;
    preload(2);
    burst(5, 3, 10, 1'b0, -1, 1'b1);

    // zero length
    burst(0, 0, 0, 1'b0, -1, 1'b0);
    chk("zero_lat", 64'(t_d - t_s), 64'd1);

    // start during RUN is ignored
    rmode = 1;
    preload(6);
    burst(6, 0, 0, 1'b0, 2, 1'b0);

    // reset mid-burst
    rmode = 0;
    preload(8);
    base = beat_q.size();
    step();
    start = 1'b1;
    burst_len = CW'(8);
    watch();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (beat_q.size() - base >= 3) break;
    end
    chk("pre_rst_beats", 64'(beat_q.size() - base), 64'd3);
    d0 = done_cnt;
    step();
    reset = 1'b1;
    watch();
    step();
    reset = 1'b0;
    watch();
    chk_zero_out();
    exp_q.delete();
    repeat (4) tick();
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    preload(4);
    burst(4, 0, 0, 1'b0, -1, 1'b0);

    // max length
    preload(15);
    burst(15, 0, 0, 1'b0, -1, 1'b0);

    // randomized bursts
    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(1, 15);
      k = $urandom_range(0, len);
      preload(k);
      burst(len, len - k, 0, 1'b1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
